// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports, two write ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to make reads return post-edge data and busy during a same-cycle write.
module regfile_mp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NRD    = 3
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]     regs_q [NREG];
  logic [DATA_W-1:0]     regs_d [NREG];
  logic [NREG-1:0]       busy_q, busy_d;
  logic [NRD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]        rd_busy_q, rd_busy_d;

  // Port 1 is applied after port 0 so it wins on an address clash; reserve is applied
  // last so a new producer claim survives a write to the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (we1) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int k = 0; k < NRD; k++) begin
`ifdef REGFILE_BYPASS_EN
      rd_data_d[k*DATA_W +: DATA_W] = regs_d[rd_addr[k*ADDR_W +: ADDR_W]];
      rd_busy_d[k]                  = busy_d[rd_addr[k*ADDR_W +: ADDR_W]];
`else
      rd_data_d[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
      rd_busy_d[k]                  = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
`endif
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default build plus a 32-bit, 16-entry, 4-port build.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        reset;
  logic [8:0]  rd_addr;
  logic [47:0] rd_data;
  logic [2:0]  rd_busy;
  logic        we0, we1, rsv_en;
  logic [2:0]  wa0, wa1, rsv_addr;
  logic [15:0] wd0, wd1;
  logic [7:0]  busy_vec;

  logic         w_we0, w_we1, w_rsv_en;
  logic [3:0]   w_wa0, w_wa1, w_rsv_addr;
  logic [31:0]  w_wd0, w_wd1;
  logic [15:0]  w_rd_addr;
  logic [127:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic [15:0]  w_busy_vec;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  regfile_mp dut (
    .CLK(CLK), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .NRD(4)) dut_w (
    .CLK(CLK), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .we0(w_we0), .we1(w_we1), .wa0(w_wa0), .wa1(w_wa1), .wd0(w_wd0), .wd1(w_wd1),
    .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr), .busy_vec(w_busy_vec)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rsv_addr = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); rd_addr = 0;
    w_we0 = 0; w_we1 = 0; w_rsv_en = 0; w_wa0 = 0; w_wa1 = 0;
    w_wd0 = 0; w_wd1 = 0; w_rsv_addr = 0; w_rd_addr = 0;
    #12;
    reset = 0;
    tick();
    // Preload every register with FFFF and mark some busy.
    for (int i = 0; i < 8; i += 2) begin
      we0 = 1; wa0 = 3'(i); wd0 = 16'hFFFF;
      we1 = 1; wa1 = 3'(i + 1); wd1 = 16'hFFFF;
      tick();
    end
    idle();
    rsv_en = 1; rsv_addr = 1;
    rd_addr = {3'd1, 3'd6, 3'd0};
    tick();
    idle();
    tick();
    tests++;
    if (rd_data !== 48'hFFFF_FFFF_FFFF || rd_busy !== 3'b100) begin
      fails++;
      $display("FAIL preload: rd_data=%h rd_busy=%b required ffffffffffff/100", rd_data, rd_busy);
    end
    #2 reset = 1;
    #1;
    tests++;
    if (rd_data !== 48'h0 || rd_busy !== 3'b0 || busy_vec !== 8'h0) begin
      fails++;
      $display("FAIL async_reset: rd_data=%h rd_busy=%b busy_vec=%b required all 0",
               rd_data, rd_busy, busy_vec);
    end
    // Writes and reserves are ignored while reset is held.
    we0 = 1; wa0 = 2; wd0 = 16'h7777; rsv_en = 1; rsv_addr = 2;
    tick();
    tests++;
    if (rd_data !== 48'h0 || busy_vec !== 8'h0) begin
      fails++;
      $display("FAIL reset_hold: rd_data=%h busy_vec=%b required 0/0", rd_data, busy_vec);
    end
    idle();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = {3'(i), 3'(i), 3'(i)};
      tick();
      tests++;
      if (rd_data !== 48'h0 || rd_busy !== 3'b0) begin
        fails++;
        $display("FAIL reset_clear r%0d: rd_data=%h rd_busy=%b required 0/0", i, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_write();
    rd_addr = 0;
    we0 = 1; wa0 = 2; wd0 = 16'h1234;
    tick();
    idle();
    rd_addr = {3'd0, 3'd0, 3'd2};
    #1;
    tests++;
    if (rd_data[15:0] !== 16'h0) begin
      fails++;
      $display("FAIL write_latency: rd_data0=%h required 0000", rd_data[15:0]);
    end
    tick();
    tests++;
    if (rd_data[15:0] !== 16'h1234) begin
      fails++;
      $display("FAIL write_p0: rd_data0=%h required 1234", rd_data[15:0]);
    end
  endtask

  task automatic test_dual_write();
    we0 = 1; wa0 = 5; wd0 = 16'hAAAA;
    we1 = 1; wa1 = 5; wd1 = 16'h5555;
    tick();
    we0 = 1; wa0 = 6; wd0 = 16'h6666;
    we1 = 1; wa1 = 7; wd1 = 16'h7777;
    tick();
    idle();
    rd_addr = {3'd7, 3'd6, 3'd5};
    tick();
    tests++;
    if (rd_data !== {16'h7777, 16'h6666, 16'h5555}) begin
      fails++;
      $display("FAIL dual_write: rd_data=%h required 777766665555", rd_data);
    end
  endtask

  task automatic test_reserve();
    rsv_en = 1; rsv_addr = 4;
    rd_addr = {3'd4, 3'd4, 3'd4};
    tick();
    tests++;
    if (busy_vec !== 8'h10) begin
      fails++;
      $display("FAIL reserve_set: busy_vec=%b required 00010000", busy_vec);
    end
    rsv_en = 1; rsv_addr = 4;
    tick();
    tests++;
    if (busy_vec !== 8'h10 || rd_busy !== 3'b111) begin
      fails++;
      $display("FAIL reserve_again: busy_vec=%b rd_busy=%b required 00010000/111", busy_vec, rd_busy);
    end
    idle();
    we1 = 1; wa1 = 4; wd1 = 16'hBEEF;
    tick();
    tests++;
    if (busy_vec !== 8'h00) begin
      fails++;
      $display("FAIL write_clears_busy: busy_vec=%b required 00000000", busy_vec);
    end
    idle();
    rsv_en = 1; rsv_addr = 4; we0 = 1; wa0 = 4; wd0 = 16'h4444;
    tick();
    idle();
    tests++;
    if (busy_vec !== 8'h10) begin
      fails++;
      $display("FAIL reserve_wins: busy_vec=%b required 00010000", busy_vec);
    end
    tick();
    tests++;
    if (rd_data !== 48'h4444_4444_4444 || rd_busy !== 3'b111) begin
      fails++;
      $display("FAIL reserve_write_data: rd_data=%h rd_busy=%b required 444444444444/111",
               rd_data, rd_busy);
    end
  endtask

  task automatic test_read_during_write();
    logic [15:0] exp_d;
    logic        exp_b;
    we0 = 1; wa0 = 3; wd0 = 16'h0001;
    tick();
    idle();
    we0 = 1; wa0 = 3; wd0 = 16'h00F0; rsv_en = 1; rsv_addr = 3;
    rd_addr = {3'd3, 3'd3, 3'd3};
`ifdef REGFILE_BYPASS_EN
    exp_d = 16'h00F0; exp_b = 1'b1;
`else
    exp_d = 16'h0001; exp_b = 1'b0;
`endif
    tick();
    idle();
    tests++;
    if (rd_data !== {3{exp_d}} || rd_busy !== {3{exp_b}}) begin
      fails++;
      $display("FAIL read_during_write: rd_data=%h rd_busy=%b required %h/%b",
               rd_data, rd_busy, {3{exp_d}}, {3{exp_b}});
    end
    tick();
    tests++;
    if (rd_data !== 48'h00F0_00F0_00F0 || rd_busy !== 3'b111) begin
      fails++;
      $display("FAIL read_after_write: rd_data=%h rd_busy=%b required 00f000f000f0/111",
               rd_data, rd_busy);
    end
  endtask

  task automatic test_wide();
    w_we0 = 1; w_wa0 = 15; w_wd0 = 32'hDEADBEEF;
    tick();
    w_we0 = 0;
    w_rd_addr = {4'd15, 4'd15, 4'd15, 4'd15};
    tick();
    tests++;
    if (w_rd_data !== {4{32'hDEADBEEF}}) begin
      fails++;
      $display("FAIL wide_r15: rd_data=%h required 4 x deadbeef", w_rd_data);
    end
    for (int i = 0; i < 15; i++) begin
      w_rd_addr = {4'(i), 4'(i), 4'(i), 4'(i)};
      tick();
      tests++;
      if (w_rd_data !== 128'h0) begin
        fails++;
        $display("FAIL wide_r%0d: rd_data=%h required 0", i, w_rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_dual_write();
    test_reserve();
    test_read_during_write();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
